dht11_reader: RTL

- Single-wire DHT11 host controller.
- Periodically triggers a measurement and decodes the 40-bit sensor frame.
- Verifies the checksum and presents integer temperature and humidity bytes to the UART string transmitter.
- Sits between the top-level open-drain pad (tristate tied off at top) and the UART reporting stage.

---
 rtl/dht11_reader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dht11_reader.sv
// dht11_reader: single-wire DHT11 host controller.
// Triggers a measurement every SAMPLE_PERIOD_MS, decodes the 40-bit frame,
// verifies the checksum and presents saturated integer temperature/humidity.
// Optional build macro DHT11_DEGLITCH_EN: require 4 stable cycles on the
// synchronized pad level before it is used for edge detection.
module dht11_reader #(
   parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
   parameter int unsigned SAMPLE_PERIOD_MS = 2000,
   parameter int unsigned START_LOW_US     = 18000,
   parameter int unsigned BIT_THRESH_US    = 50,
   parameter int unsigned TIMEOUT_US       = 200
) (
   input  logic       clk_100Mhz,
   input  logic       rst_n,
   input  logic       dht_in,
   output logic       dht_drive_low,
   output logic [7:0] temperature,
   output logic [7:0] humidity,
   output logic       data_valid,
   output logic       checksum_error,
   output logic       sensor_timeout
);

   localparam logic [31:0] DIV_LAST  = 32'(CLK_FREQ_HZ / 1_000_000 - 1);
   localparam logic [31:0] PERIOD_US = 32'(SAMPLE_PERIOD_MS * 1000);
   localparam logic [31:0] START_US  = 32'(START_LOW_US);
   localparam logic [31:0] THRESH_US = 32'(BIT_THRESH_US);
   localparam logic [31:0] TMO_US    = 32'(TIMEOUT_US);

   typedef enum logic [2:0] {
      IDLE, START, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] div_cnt_q, us_cnt_q, us_cnt_d;
   logic [39:0] shift_q, shift_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  temp_q, temp_d, hum_q, hum_d, sum;
   logic        valid_q, valid_d, ck_q, ck_d, tmo_q, tmo_d;
   logic        sync1_q, sync2_q, level, level_prev_q, fall, rise, tick, waiting;

   // Two-flop synchronizer for the asynchronous pad level.
   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= dht_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef DHT11_DEGLITCH_EN
   logic       filt_q, filt_d;
   logic [1:0] stab_q, stab_d;

   // Accept a new level only after it has held for 4 consecutive cycles.
   always_comb begin
      filt_d = filt_q;
      stab_d = '0;
      if (sync2_q != filt_q) begin
         if (stab_q == 2'd3) filt_d = sync2_q;
         else                stab_d = stab_q + 2'd1;
      end
   end

   // Deglitch filter registers.
   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 1'b1;
         stab_q <= '0;
      end else begin
         filt_q <= filt_d;
         stab_q <= stab_d;
      end
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   assign fall    = level_prev_q & ~level;
   assign rise    = ~level_prev_q & level;
   assign tick    = (div_cnt_q == DIV_LAST);
   assign waiting = (state_q inside {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH});
   assign sum     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

   // Next-state, frame shift and result update logic.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      temp_d    = temp_q;
      hum_d     = hum_q;
      valid_d   = 1'b0;
      ck_d      = ck_q;
      tmo_d     = tmo_q;
      case (state_q)
         IDLE:      if (us_cnt_q >= PERIOD_US) state_d = START;
         START:     if (us_cnt_q >= START_US)  state_d = WAIT_RESP;
         WAIT_RESP: if (fall) state_d = RESP_LOW;
         RESP_LOW:  if (rise) state_d = RESP_HIGH;
         RESP_HIGH: if (fall) begin
                       state_d   = BIT_LOW;
                       bit_cnt_d = '0;
                    end
         BIT_LOW:   if (rise) state_d = BIT_HIGH;
         BIT_HIGH:  if (fall) begin
                       shift_d   = {shift_q[38:0], (us_cnt_q > THRESH_US)};
                       bit_cnt_d = bit_cnt_q + 6'd1;
                       state_d   = (bit_cnt_q == 6'd39) ? CHECK : BIT_LOW;
                    end
         CHECK: begin
            state_d = IDLE;
            tmo_d   = 1'b0;
            if (sum == shift_q[7:0]) begin
               hum_d   = (shift_q[39:32] > 8'd99) ? 8'd99 : shift_q[39:32];
               temp_d  = (shift_q[23:16] > 8'd99) ? 8'd99 : shift_q[23:16];
               valid_d = 1'b1;
               ck_d    = 1'b0;
            end else begin
               ck_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A wait state with no qualifying edge aborts once its phase count expires.
      if (waiting && (state_d == state_q) && (us_cnt_q >= TMO_US)) begin
         state_d = IDLE;
         tmo_d   = 1'b1;
         ck_d    = 1'b0;
      end
   end

   // Phase counter in microseconds, cleared on every state change.
   always_comb begin
      us_cnt_d = us_cnt_q;
      if (state_d != state_q) us_cnt_d = '0;
      else if (tick)          us_cnt_d = us_cnt_q + 32'd1;
   end

   // State, counters and output registers.
   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         div_cnt_q    <= '0;
         us_cnt_q     <= '0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         temp_q       <= '0;
         hum_q        <= '0;
         valid_q      <= 1'b0;
         ck_q         <= 1'b0;
         tmo_q        <= 1'b0;
         level_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= tick ? '0 : div_cnt_q + 32'd1;
         us_cnt_q     <= us_cnt_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         temp_q       <= temp_d;
         hum_q        <= hum_d;
         valid_q      <= valid_d;
         ck_q         <= ck_d;
         tmo_q        <= tmo_d;
         level_prev_q <= level;
      end
   end

   assign dht_drive_low  = (state_q == START);
   assign temperature    = temp_q;
   assign humidity       = hum_q;
   assign data_valid     = valid_q;
   assign checksum_error = ck_q;
   assign sensor_timeout = tmo_q;

endmodule
